audio_peak_reporter: RTL and testbench
======================================

Name: audio_peak_reporter

Overview:
Peripheral on the far side of the PicoBlaze input port 0 and interrupt line. It watches the audio sample stream and measures the peak absolute amplitude over a fixed window of samples. At the end of each window it presents the result as an 8-bit level and raises an interrupt request. It holds that level stable until the processor acknowledges the read, and re-requests the interrupt if no acknowledge arrives.

Parameters:
SAMPLE_W, 16, width of signed two's-complement audio samples (minimum 9)
WINDOW_SAMPLES, 1024, valid samples per measurement window (minimum 1)
RETRY_CYCLES, 2500000, clk cycles to wait for rd_ack before re-pulsing interr_sig (100 ms at 25 MHz); 0 disables retry

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sample_valid  input  1  qualifies sample_data for one clk cycle
sample_data  input  SAMPLE_W  signed audio sample
rd_ack  input  1  one-cycle pulse when processor reads port 0 (read_strobe & port_id==0), generated outside this block
level_data  output  8  latched peak level; drives the input_data bus of the processor wrapper
interr_sig  output  1  one-cycle interrupt request pulse
overrun  output  1  sticky flag: a window result replaced an unacknowledged one

Behaviour:
- Reset (reset_n low, asynchronous): level_data=0, interr_sig=0, overrun=0, peak accumulator=0, window counter=0, retry counter=0, FSM=IDLE.
- Magnitude: mag = |sample_data|, SAMPLE_W-1 bits unsigned. The most-negative value saturates to all-ones (-32768 -> 32767).
- Peak: on each sample_valid, peak <= max(peak, mag).
- Window counter: 0..WINDOW_SAMPLES-1, increments per valid sample.
- End of window: the sample with counter==WINDOW_SAMPLES-1 ends the window. On that edge:
  - level_data <= max(peak, mag)[SAMPLE_W-2 : SAMPLE_W-9], i.e. the top 8 magnitude bits.
  - peak <= 0 and counter <= 0.
  - The "latch" event fires.
- The next window's first sample may arrive on the very next cycle with no gap; it is compared against 0.
- Latency: the final sample is valid in cycle N. level_data shows the new value from cycle N+1, and interr_sig is high in cycle N+1 only.
- FSM:
  - IDLE: on latch -> PULSE.
  - PULSE: interr_sig=1 for exactly one cycle; retry counter cleared; -> WAIT_ACK.
  - WAIT_ACK: retry counter increments every cycle.
    - On rd_ack -> IDLE.
    - On latch -> PULSE, and overrun <= 1.
    - RETRY_CYCLES!=0 and retry counter == RETRY_CYCLES-1 -> PULSE (same level_data, no overrun).
- level_data changes only on latch, never on rd_ack or retry.
- Simultaneous rd_ack and latch in WAIT_ACK: the ack consumes the old result; go to PULSE for the new result; overrun NOT set.
- rd_ack in IDLE or PULSE: ignored, except that it clears overrun.
- Latch while in PULSE: level_data updates, overrun <= 1, and the FSM re-enters PULSE, so interr_sig stays high one extra cycle.
- overrun: set as above; cleared by any rd_ack. Set wins over clear when both occur in the same cycle.
- sample_valid low: no state change except FSM and retry counter progress.
- Reset asserted mid-window: the partial window is discarded; no interrupt is emitted for it.

Test Plan:
(Bench parameters for all scenarios: SAMPLE_W=16, WINDOW_SAMPLES=4, RETRY_CYCLES=16.)
1. Basic window: samples 0x0100, -0x4000, 0x0200, 0x0010 on consecutive cycles -> level_data=0x80 one cycle after 4th sample; interr_sig high exactly that cycle.
2. Saturation: window containing 0x8000 (-32768) -> level_data=0xFF. Next window of all zeros -> level_data=0x00 and a new interr_sig pulse.
3. Acknowledge: after scenario 1, pulse rd_ack 3 cycles after interr_sig -> FSM IDLE; no further interr_sig pulse for 40 cycles with sample_valid low.
4. Retry: no rd_ack after a window -> interr_sig re-pulses 17 cycles after the first pulse and every 17 cycles after that; level_data constant; overrun=0.
5. Overrun and simultaneity:
   - Two windows with no rd_ack -> overrun=1 and level_data = second result.
   - rd_ack then clears overrun.
   - Repeat with rd_ack on the same cycle as the second latch -> overrun stays 0 and interr_sig pulses.
6. Async reset: drop reset_n between clock edges after 2 samples of a window -> all outputs 0 immediately. After release, 4 new samples are needed before interr_sig.

Source files
------------

// File: rtl/audio_peak_reporter.sv
// audio_peak_reporter
// Tracks the peak absolute amplitude of the audio sample stream over a
// fixed window, latches the top 8 magnitude bits at the end of each window
// and requests an interrupt. The request repeats every RETRY_CYCLES until
// the processor acknowledges the read of port 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no unacknowledged result outstanding
// PULSE    | interr_sig high this cycle for a fresh or retried result
// WAIT_ACK | result presented, counting towards a retry, waiting rd_ack
module audio_peak_reporter #(
  parameter int SAMPLE_W       = 16,
  parameter int WINDOW_SAMPLES = 1024,
  parameter int RETRY_CYCLES   = 2500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                rd_ack,
  output logic [7:0]          level_data,
  output logic                interr_sig,
  output logic                overrun
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam int RT_W  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam int RT_LAST_I = (RETRY_CYCLES > 0) ? RETRY_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(RT_LAST_I);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t state, state_next;

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] peak;
  logic [MAG_W-1:0] peak_next;
  logic [CNT_W-1:0] win_cnt;
  logic [RT_W-1:0]  retry_cnt;
  logic             latch;
  logic             retry_hit;
  logic             ovr_set;

  // Absolute value of the sample; the most-negative code has no positive
  // counterpart and saturates to all-ones.
  always_comb begin
    mag = sample_data[MAG_W-1:0];
    if (sample_data[SAMPLE_W-1]) begin
      if (sample_data[MAG_W-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~sample_data[MAG_W-1:0] + 1'b1;
      end
    end
  end

  assign peak_next = (mag > peak) ? mag : peak;
  assign latch     = sample_valid && (win_cnt == WIN_LAST);
  assign retry_hit = (RETRY_CYCLES != 0) && (state == WAIT_ACK) && (retry_cnt == RT_LAST);
  assign ovr_set   = latch && ((state == PULSE) || ((state == WAIT_ACK) && !rd_ack));

  // Peak accumulation, window counting and result latching.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak       <= '0;
      win_cnt    <= '0;
      level_data <= '0;
    end else if (sample_valid) begin
      if (latch) begin
        level_data <= peak_next[MAG_W-1 -: 8];
        peak       <= '0;
        win_cnt    <= '0;
      end else begin
        peak    <= peak_next;
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a new result outranks an acknowledge, and an
  // acknowledge outranks a retry that falls on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (latch) state_next = PULSE;
      end
      PULSE: begin
        state_next = latch ? PULSE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (latch)          state_next = PULSE;
        else if (rd_ack)    state_next = IDLE;
        else if (retry_hit) state_next = PULSE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: interrupt request is high for every cycle spent in PULSE.
  always_comb begin
    interr_sig = (state == PULSE);
  end

  // Retry timer: restarted by each pulse, advances while waiting for rd_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
    end else if (state == PULSE) begin
      retry_cnt <= '0;
    end else if (state == WAIT_ACK) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Sticky overrun flag; a new set beats a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (rd_ack) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_peak_reporter.sv
// Testbench for audio_peak_reporter: directed scenarios followed by random
// traffic, every cycle compared against a window/interrupt reference model.
module tb_audio_peak_reporter;

  localparam int SAMPLE_W = 16;
  localparam int WIN      = 4;
  localparam int RETRY    = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_data = '0;
  logic                rd_ack = 1'b0;
  logic [7:0]          level_data;
  logic                interr_sig;
  logic                overrun;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_mags[$];
  int m_level;
  bit m_irq;
  bit m_unacked;
  bit m_ovr;
  int m_cyc;
  int m_last;

  audio_peak_reporter #(
    .SAMPLE_W(SAMPLE_W),
    .WINDOW_SAMPLES(WIN),
    .RETRY_CYCLES(RETRY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .rd_ack(rd_ack),
    .level_data(level_data),
    .interr_sig(interr_sig),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mags.delete();
    m_level   = 0;
    m_irq     = 0;
    m_unacked = 0;
    m_ovr     = 0;
    m_cyc     = 0;
    m_last    = 0;
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_edge();
    bit latch;
    bit set_ovr;
    bit nxt;
    int s;
    int m;
    int mx;
    latch = 0;
    if (sample_valid) begin
      s = int'($signed(sample_data));
      m = (s < 0) ? -s : s;
      if (m > 32767) m = 32767;
      m_mags.push_back(m);
      if (m_mags.size() == WIN) begin
        mx = 0;
        foreach (m_mags[i]) if (m_mags[i] > mx) mx = m_mags[i];
        m_level = mx / 128;
        m_mags.delete();
        latch = 1;
      end
    end
    set_ovr = latch && (m_irq || (m_unacked && !rd_ack));
    if (set_ovr) m_ovr = 1;
    else if (rd_ack) m_ovr = 0;
    if (rd_ack && !m_irq) m_unacked = 0;
    nxt = latch || (RETRY != 0 && m_unacked && !m_irq && (m_cyc + 1 - m_last) == RETRY + 1);
    m_cyc++;
    if (nxt) begin
      m_last    = m_cyc;
      m_unacked = 1;
    end
    m_irq = nxt;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic ack);
    sample_valid = v;
    sample_data  = d;
    rd_ack       = ack;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", level_data, m_level);
    chk("irq", interr_sig, m_irq);
    chk("ovr", overrun, m_ovr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_level", level_data, 8'h00);
    chk("rst_irq", interr_sig, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    idle(2);

    // 1: basic window, then 3: ack three cycles after the pulse
    step(1, 16'h0100, 0);
    step(1, 16'hC000, 0);
    step(1, 16'h0200, 0);
    step(1, 16'h0010, 0);
    chk("s1_level", level_data, 8'h80);
    chk("s1_irq", interr_sig, 1'b1);
    idle(2);
    chk("s1_irq_once", interr_sig, 1'b0);
    step(0, 16'h0, 1);
    idle(40);
    chk("s3_quiet", interr_sig, 1'b0);

    // 2: saturation window, then an all-zero window
    step(1, 16'h0005, 0);
    step(1, 16'h8000, 0);
    step(1, 16'h7000, 0);
    step(1, 16'h0001, 0);
    chk("s2_sat", level_data, 8'hFF);
    step(0, 16'h0, 1);
    step(0, 16'h0, 1);
    for (int i = 0; i < WIN; i++) step(1, 16'h0000, 0);
    chk("s2_zero", level_data, 8'h00);
    chk("s2_irq", interr_sig, 1'b1);

    // 4: retry spacing of 17 cycles, twice, level constant
    for (int r = 0; r < 2; r++) begin
      idle(16);
      chk("s4_gap", interr_sig, 1'b0);
      idle(1);
      chk("s4_retry", interr_sig, 1'b1);
      chk("s4_level", level_data, 8'h00);
      chk("s4_ovr", overrun, 1'b0);
    end
    step(0, 16'h0, 1);
    idle(1);

    // 5a: two back-to-back windows without ack -> overrun
    step(1, 16'h1000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'hF000, 0);
    step(1, 16'h0800, 0);
    step(1, 16'h0000, 0);
    chk("s5_ovr", overrun, 1'b1);
    chk("s5_level", level_data, 8'h20);
    idle(2);
    step(0, 16'h0, 1);
    chk("s5_clear", overrun, 1'b0);
    idle(1);

    // 5b: ack lands on the cycle of the second latch
    for (int i = 0; i < WIN; i++) step(1, 16'h0400, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    step(1, 16'h2000, 1);
    chk("s5b_ovr", overrun, 1'b0);
    chk("s5b_irq", interr_sig, 1'b1);
    chk("s5b_level", level_data, 8'h40);
    idle(2);

    // 6: async reset mid-window after an overrun left outputs non-zero
    for (int i = 0; i < 2 * WIN; i++) step(1, 16'h3000, 0);
    step(1, 16'h0100, 0);
    step(1, 16'h0100, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_level", level_data, 8'h00);
    chk("s6_irq", interr_sig, 1'b0);
    chk("s6_ovr", overrun, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    for (int i = 0; i < WIN - 1; i++) step(1, 16'h0300, 0);
    chk("s6_no_irq", interr_sig, 1'b0);
    step(1, 16'h0300, 0);
    chk("s6_irq", interr_sig, 1'b1);
    step(0, 16'h0, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      d = 16'($urandom);
      if (sel == 0) d = 16'h8000;
      else if (sel == 1) d = 16'h0000;
      else if (sel == 2) d = 16'h7FFF;
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, d,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
